// File: rtl/tlk2711_axi_rd_arb_if.sv
`default_nettype none
// ============================================================================
//  Module   : tlk2711_axi_rd_arb_if
//  Purpose  : AXI read-channel bundle (AR + R) shared by the two tlk2711
//             requesters and the PS HP port.
//  Modports : master - drives AR request and R ready (arbiter -> PS HP port)
//             slave  - drives AR ready and R data/resp/last/valid
//                      (arbiter -> tlk2711 requester)
//  Revision : 1.0 - initial release
// ============================================================================
interface tlk2711_axi_rd_arb_if #(
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64
);
    // AR channel
    logic                  arvalid;
    logic                  arready;
    logic [3:0]            arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [3:0]            arcache;
    logic [2:0]            arprot;

    // R channel
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst, arcache, arprot,
        output rready,
        input  arready,
        input  rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst, arcache, arprot,
        input  rready,
        output arready,
        output rdata, rresp, rlast, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/tlk2711_axi_rd_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tlk2711_axi_rd_arb
//  Purpose  : Two-to-one AXI read arbiter between the tlk2711a (s0) and
//             tlk2711b (s1) requesters and a single PS HP read port (m).
//             Round-robin grant, one burst outstanding, per-port status.
//  Ports    : clk, rst_n       - clock, asynchronous active-low reset
//             s0, s1           - AXI read slave bundles (requesters)
//             m                - AXI read master bundle (PS HP port)
//             i_stat_clr       - synchronous clear of status registers
//             o_grant_cnt0/1   - completed-burst count per port (wrapping)
//             o_rresp_err[1:0] - sticky non-OKAY RRESP flag per port
//             o_len_err[1:0]   - sticky RLAST/ARLEN mismatch flag per port
//             o_busy           - FSM not in IDLE
//  Revision : 1.0 - initial release
// ============================================================================
module tlk2711_axi_rd_arb #(
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    tlk2711_axi_rd_arb_if.slave         s0,
    tlk2711_axi_rd_arb_if.slave         s1,
    tlk2711_axi_rd_arb_if.master        m,
    input  logic                        i_stat_clr,
    output logic [15:0]                 o_grant_cnt0,
    output logic [15:0]                 o_grant_cnt1,
    output logic [1:0]                  o_rresp_err,
    output logic [1:0]                  o_len_err,
    output logic                        o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_grant;
    logic                  r_last_grant;
    logic                  r_arvalid;
    logic [2:0]            r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic [3:0]            r_cache;
    logic [2:0]            r_prot;
    logic [7:0]            r_beat_cnt;
    logic [15:0]           r_grant_cnt0;
    logic [15:0]           r_grant_cnt1;
    logic [1:0]            r_rresp_err;
    logic [1:0]            r_len_err;

    logic w_idle;
    logic w_win;
    logic w_accept;
    logic w_data;
    logic w_to0;
    logic w_to1;
    logic w_m_rready;
    logic w_beat;
    logic w_unused_id;

    // arready is combinational, so it must also be forced low while rst_n
    // is asserted, not just once the state register has been cleared.
    assign w_idle   = rst_n && (r_state == ST_IDLE);

    // Contention goes to the port opposite the last completed grant; a lone
    // requester always wins.
    assign w_win    = (s0.arvalid && s1.arvalid) ? ~r_last_grant : s1.arvalid;
    assign w_accept = w_idle && (s0.arvalid || s1.arvalid);

    assign s0.arready = w_accept && !w_win;
    assign s1.arready = w_accept &&  w_win;

    // The requester's arid[3] is replaced by the grant bit on the master side.
    assign w_unused_id = s0.arid[3] ^ s1.arid[3];

    // ------------------------------------------------------------------
    // AR master: driven only from latched fields, stable while stalled
    // ------------------------------------------------------------------
    assign m.arvalid = r_arvalid;
    assign m.arid    = {r_grant, r_id};
    assign m.araddr  = r_addr;
    assign m.arlen   = r_len;
    assign m.arsize  = r_size;
    assign m.arburst = r_burst;
    assign m.arcache = r_cache;
    assign m.arprot  = r_prot;

    // ------------------------------------------------------------------
    // R routing: only the granted port sees data, the other reads zero
    // ------------------------------------------------------------------
    assign w_data     = (r_state == ST_DATA);
    assign w_to0      = w_data && !r_grant;
    assign w_to1      = w_data &&  r_grant;
    assign w_m_rready = w_data && (r_grant ? s1.rready : s0.rready);
    assign w_beat     = m.rvalid && w_m_rready;
    assign m.rready   = w_m_rready;

    assign s0.rvalid  = w_to0 && m.rvalid;
    assign s0.rdata   = w_to0 ? m.rdata : '0;
    assign s0.rresp   = w_to0 ? m.rresp : 2'b00;
    assign s0.rlast   = w_to0 && m.rlast;

    assign s1.rvalid  = w_to1 && m.rvalid;
    assign s1.rdata   = w_to1 ? m.rdata : '0;
    assign s1.rresp   = w_to1 ? m.rresp : 2'b00;
    assign s1.rlast   = w_to1 && m.rlast;

    // ------------------------------------------------------------------
    // FSM, request latch, beat counter and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_arvalid    <= 1'b0;
            r_id         <= '0;
            r_addr       <= '0;
            r_len        <= '0;
            r_size       <= '0;
            r_burst      <= '0;
            r_cache      <= '0;
            r_prot       <= '0;
            r_beat_cnt   <= '0;
            r_grant_cnt0 <= '0;
            r_grant_cnt1 <= '0;
            r_rresp_err  <= '0;
            r_len_err    <= '0;
        end else begin
            // Clear first; any set/increment below overrides it for the
            // affected bit or counter.
            if (i_stat_clr) begin
                r_grant_cnt0 <= '0;
                r_grant_cnt1 <= '0;
                r_rresp_err  <= '0;
                r_len_err    <= '0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_grant   <= w_win;
                        r_id      <= w_win ? s1.arid[2:0] : s0.arid[2:0];
                        r_addr    <= w_win ? s1.araddr    : s0.araddr;
                        r_len     <= w_win ? s1.arlen     : s0.arlen;
                        r_size    <= w_win ? s1.arsize    : s0.arsize;
                        r_burst   <= w_win ? s1.arburst   : s0.arburst;
                        r_cache   <= w_win ? s1.arcache   : s0.arcache;
                        r_prot    <= w_win ? s1.arprot    : s0.arprot;
                        r_arvalid <= 1'b1;
                        r_state   <= ST_ADDR;
                    end
                end

                ST_ADDR: begin
                    if (m.arready) begin
                        r_arvalid  <= 1'b0;
                        r_beat_cnt <= '0;
                        r_state    <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                        if (m.rresp != 2'b00) begin
                            r_rresp_err[r_grant] <= 1'b1;
                        end
                        if (m.rlast) begin
                            // Counter still holds the pre-increment index,
                            // which must equal arlen on the final beat.
                            if (r_beat_cnt != r_len) begin
                                r_len_err[r_grant] <= 1'b1;
                            end
                            if (r_grant) begin
                                r_grant_cnt1 <= r_grant_cnt1 + 16'd1;
                            end else begin
                                r_grant_cnt0 <= r_grant_cnt0 + 16'd1;
                            end
                            r_last_grant <= r_grant;
                            r_state      <= ST_IDLE;
                        end else if (r_beat_cnt == r_len) begin
                            // Slave overran the burst without RLAST; keep
                            // forwarding and wait for RLAST to terminate.
                            r_len_err[r_grant] <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_grant_cnt0 = r_grant_cnt0;
    assign o_grant_cnt1 = r_grant_cnt1;
    assign o_rresp_err  = r_rresp_err;
    assign o_len_err    = r_len_err;
    assign o_busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tlk2711_axi_rd_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tlk2711_axi_rd_arb
//  Purpose  : Directed self-checking bench for tlk2711_axi_rd_arb.
//             Inputs change on the falling edge, outputs are sampled 1 ns
//             later, well away from the rising (active) edge.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tlk2711_axi_rd_arb;

    localparam int c_AW = 48;
    localparam int c_DW = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_stat_clr;
    logic [15:0] o_grant_cnt0;
    logic [15:0] o_grant_cnt1;
    logic [1:0]  o_rresp_err;
    logic [1:0]  o_len_err;
    logic        o_busy;

    int n_chk  = 0;
    int n_fail = 0;

    tlk2711_axi_rd_arb_if #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW)) s0_if ();
    tlk2711_axi_rd_arb_if #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW)) s1_if ();
    tlk2711_axi_rd_arb_if #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW)) m_if  ();

    tlk2711_axi_rd_arb #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s0           (s0_if),
        .s1           (s1_if),
        .m            (m_if),
        .i_stat_clr   (i_stat_clr),
        .o_grant_cnt0 (o_grant_cnt0),
        .o_grant_cnt1 (o_grant_cnt1),
        .o_rresp_err  (o_rresp_err),
        .o_len_err    (o_len_err),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a lone request on one port, check the grant and the AR master
    // one cycle later. m_if.arready is expected high so DATA follows.
    task automatic issue(input int port, input logic [47:0] addr,
                         input logic [7:0] len, input logic [3:0] id);
        logic [3:0] exp_id;
        exp_id = {port[0], id[2:0]};
        @(negedge clk);
        if (port == 0) begin
            s0_if.arvalid = 1'b1; s0_if.araddr = addr; s0_if.arlen = len; s0_if.arid = id;
        end else begin
            s1_if.arvalid = 1'b1; s1_if.araddr = addr; s1_if.arlen = len; s1_if.arid = id;
        end
        #1;
        chk("arready_win",  (port == 0) ? s0_if.arready : s1_if.arready, 1'b1);
        chk("arready_lose", (port == 0) ? s1_if.arready : s0_if.arready, 1'b0);
        @(negedge clk);
        if (port == 0) s0_if.arvalid = 1'b0; else s1_if.arvalid = 1'b0;
        #1;
        chk("m_arvalid", m_if.arvalid, 1'b1);
        chk("m_araddr",  m_if.araddr,  addr);
        chk("m_arlen",   m_if.arlen,   len);
        chk("m_arid",    m_if.arid,    exp_id);
    endtask

    // Drive one R beat and check it reaches only the granted port.
    task automatic beat(input int port, input logic [63:0] d,
                        input logic [1:0] resp, input logic last);
        @(negedge clk);
        m_if.rvalid = 1'b1; m_if.rdata = d; m_if.rresp = resp; m_if.rlast = last;
        #1;
        if (port == 0) begin
            chk("s0_rvalid", s0_if.rvalid, 1'b1);
            chk("s0_rdata",  s0_if.rdata,  d);
            chk("s0_rlast",  s0_if.rlast,  last);
            chk("s1_rvalid_off", s1_if.rvalid, 1'b0);
            chk("s1_rdata_zero", s1_if.rdata,  64'd0);
        end else begin
            chk("s1_rvalid", s1_if.rvalid, 1'b1);
            chk("s1_rdata",  s1_if.rdata,  d);
            chk("s1_rlast",  s1_if.rlast,  last);
            chk("s0_rvalid_off", s0_if.rvalid, 1'b0);
            chk("s0_rdata_zero", s0_if.rdata,  64'd0);
        end
        chk("m_rready", m_if.rready, 1'b1);
    endtask

    task automatic rdone();
        @(negedge clk);
        m_if.rvalid = 1'b0; m_if.rlast = 1'b0; m_if.rresp = 2'b00;
        #1;
    endtask

    task automatic stat_clear();
        @(negedge clk);
        i_stat_clr = 1'b1;
        @(negedge clk);
        i_stat_clr = 1'b0;
        #1;
    endtask

    initial begin
        rst_n = 1'b1; i_stat_clr = 1'b0;
        s0_if.arvalid = 1'b1; s0_if.arid = '0; s0_if.araddr = '0; s0_if.arlen = '0;
        s0_if.arsize = 3'd3; s0_if.arburst = 2'b01; s0_if.arcache = 4'h3; s0_if.arprot = 3'd0;
        s0_if.rready = 1'b1;
        s1_if.arvalid = 1'b0; s1_if.arid = '0; s1_if.araddr = '0; s1_if.arlen = '0;
        s1_if.arsize = 3'd3; s1_if.arburst = 2'b01; s1_if.arcache = 4'h3; s1_if.arprot = 3'd0;
        s1_if.rready = 1'b1;
        m_if.arready = 1'b1; m_if.rvalid = 1'b0; m_if.rdata = '0; m_if.rresp = 2'b00; m_if.rlast = 1'b0;
        #1 rst_n = 1'b0;

        // ---- reset state (s0 requesting must still see arready low) ----
        @(negedge clk); #1;
        chk("rst_busy",      o_busy,        1'b0);
        chk("rst_m_arvalid", m_if.arvalid,  1'b0);
        chk("rst_m_rready",  m_if.rready,   1'b0);
        chk("rst_s0_arready", s0_if.arready, 1'b0);
        chk("rst_s0_rvalid", s0_if.rvalid,  1'b0);
        chk("rst_cnt0",      o_grant_cnt0,  16'd0);
        chk("rst_len_err",   o_len_err,     2'b00);
        chk("rst_m_arid",    m_if.arid,     4'd0);
        @(negedge clk);
        s0_if.arvalid = 1'b0;
        rst_n = 1'b1;

        // ---- s0 alone, arlen=3, addr 0x1000 ----
        issue(0, 48'h1000, 8'd3, 4'hA);
        for (int k = 0; k < 4; k++) beat(0, 64'hA000 + 64'(k), 2'b00, k == 3);
        rdone();
        chk("t1_cnt0",    o_grant_cnt0, 16'd1);
        chk("t1_busy",    o_busy,       1'b0);
        chk("t1_len_err", o_len_err,    2'b00);

        // ---- both ports continuously, arlen=0: alternate from reset ----
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        s0_if.arvalid = 1'b1; s0_if.araddr = 48'h2000; s0_if.arlen = 8'd0; s0_if.arid = 4'h1;
        s1_if.arvalid = 1'b1; s1_if.araddr = 48'h3000; s1_if.arlen = 8'd0; s1_if.arid = 4'h5;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("alt_s0_arready", s0_if.arready, (i % 2) == 0);
            chk("alt_s1_arready", s1_if.arready, (i % 2) == 1);
            @(negedge clk);
            m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
            #1;
            chk("alt_m_arvalid", m_if.arvalid, 1'b1);
            chk("alt_m_arid3",   m_if.arid[3], (i % 2) == 1);
            chk("alt_araddr",    m_if.araddr,  ((i % 2) == 0) ? 48'h2000 : 48'h3000);
            chk("alt_no_arready", {s0_if.arready, s1_if.arready}, 2'b00);
            beat(i % 2, 64'h100 + 64'(i), 2'b00, 1'b1);
            @(negedge clk);
        end
        s0_if.arvalid = 1'b0; s1_if.arvalid = 1'b0;
        m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
        #1;
        chk("alt_cnt0", o_grant_cnt0, 16'd2);
        chk("alt_cnt1", o_grant_cnt1, 16'd2);

        // ---- AR stall: m_arready low 5 cycles, s1 waiting ----
        @(negedge clk);
        m_if.arready = 1'b0;
        s0_if.arvalid = 1'b1; s0_if.araddr = 48'h4000; s0_if.arlen = 8'd0; s0_if.arid = 4'h3;
        s1_if.arvalid = 1'b1; s1_if.araddr = 48'h5000; s1_if.arlen = 8'd0; s1_if.arid = 4'h6;
        #1;
        chk("stall_s0_arready", s0_if.arready, 1'b1);
        chk("stall_s1_lose",    s1_if.arready, 1'b0);
        @(negedge clk);
        s0_if.arvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_m_arvalid", m_if.arvalid,  1'b1);
            chk("stall_m_araddr",  m_if.araddr,   48'h4000);
            chk("stall_m_arid",    m_if.arid,     4'h3);
            chk("stall_s1_arready", s1_if.arready, 1'b0);
            @(negedge clk);
        end
        m_if.arready = 1'b1;
        beat(0, 64'h4444, 2'b00, 1'b1);
        issue(1, 48'h5000, 8'd0, 4'h6);
        beat(1, 64'h5555, 2'b00, 1'b1);
        rdone();
        chk("stall_cnt0", o_grant_cnt0, 16'd3);
        chk("stall_cnt1", o_grant_cnt1, 16'd3);

        // ---- arlen=7, RLAST on beat 4 ----
        issue(0, 48'h6000, 8'd7, 4'h1);
        for (int k = 0; k < 4; k++) beat(0, 64'h6000 + 64'(k), 2'b00, k == 3);
        rdone();
        chk("short_len_err", o_len_err,    2'b01);
        chk("short_busy",    o_busy,       1'b0);
        chk("short_cnt0",    o_grant_cnt0, 16'd4);
        stat_clear();
        chk("clr_len_err", o_len_err,    2'b00);
        chk("clr_cnt0",    o_grant_cnt0, 16'd0);
        chk("clr_cnt1",    o_grant_cnt1, 16'd0);

        // ---- overrun: arlen=0 on port 1 but RLAST on the second beat ----
        issue(1, 48'h7000, 8'd0, 4'h2);
        beat(1, 64'h7000, 2'b00, 1'b0);
        beat(1, 64'h7001, 2'b00, 1'b1);
        rdone();
        chk("over_len_err", o_len_err, 2'b10);
        chk("over_busy",    o_busy,    1'b0);
        stat_clear();

        // ---- RRESP=SLVERR on beat 2 of port 1 ----
        issue(1, 48'h8000, 8'd2, 4'h7);
        beat(1, 64'h8000, 2'b00, 1'b0);
        beat(1, 64'h8001, 2'b10, 1'b0);
        beat(1, 64'h8002, 2'b00, 1'b1);
        rdone();
        chk("resp_err",     o_rresp_err,  2'b10);
        chk("resp_len_err", o_len_err,    2'b00);
        chk("resp_cnt1",    o_grant_cnt1, 16'd1);

        // ---- reset pulsed mid-burst ----
        issue(0, 48'h9000, 8'd3, 4'h4);
        beat(0, 64'h9000, 2'b00, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        s0_if.arvalid = 1'b1;
        #1;
        chk("mid_busy",      o_busy,        1'b0);
        chk("mid_m_arvalid", m_if.arvalid,  1'b0);
        chk("mid_m_rready",  m_if.rready,   1'b0);
        chk("mid_s0_rvalid", s0_if.rvalid,  1'b0);
        chk("mid_s0_arready", s0_if.arready, 1'b0);
        chk("mid_cnt1",      o_grant_cnt1,  16'd0);
        chk("mid_rresp_err", o_rresp_err,   2'b00);
        chk("mid_m_araddr",  m_if.araddr,   48'h0);
        @(negedge clk);
        rst_n = 1'b1;
        m_if.rvalid = 1'b0;
        #1;
        chk("post_rst_arready", s0_if.arready, 1'b1);
        @(negedge clk);
        s0_if.arvalid = 1'b0;
        #1;
        chk("post_rst_arvalid", m_if.arvalid, 1'b1);
        chk("post_rst_araddr",  m_if.araddr,  48'h9000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tlk2711_axi_rd_arb.md
TLK2711_AXI_RD_ARB -- requirements
Module: tlk2711_axi_rd_arb

Interface
REQ-001 Parameter ADDR_WIDTH, default 48, AXI read address width.
REQ-002 Parameter DATA_WIDTH, default 64, AXI read data width.
REQ-003 Port clk, input, 1, the single clock for all logic.
REQ-004 Port rst_n, input, 1, reset; asynchronous assertion, active-low.
REQ-005 Port s0_ar{valid,ready,id,addr,len,size,burst,cache,prot}: in/out/in..., widths 1/1/4/ADDR_WIDTH/8/3/2/4/3, AR slave bundle for the tlk2711a requester.
REQ-006 Port s0_r{data,resp,last,valid,ready}: out/out/out/out/in, widths DATA_WIDTH/2/1/1/1, R slave bundle for tlk2711a.
REQ-007 Port s1_ar* and s1_r*, identical to s0, slave bundles for the tlk2711b requester.
REQ-008 Port m_ar{valid,ready,id,addr,len,size,burst,cache,prot}: out/in/out..., same widths, shared AR master to the PS HP port.
REQ-009 Port m_r{data,resp,last,valid,ready}: in/in/in/in/out, R master from the PS HP port.
REQ-010 Port i_stat_clr, input, 1, synchronous clear of the status registers.
REQ-011 Port o_grant_cnt0 and o_grant_cnt1, output, 16 each, completed-burst counts per port.
REQ-012 Port o_rresp_err, output, 2, sticky flag per port, set on non-OKAY RRESP.
REQ-013 Port o_len_err, output, 2, sticky flag per port, set on an RLAST/ARLEN mismatch.
REQ-014 Port o_busy, output, 1, high whenever the state is not IDLE.

Function
REQ-015 The block SHALL implement a three-state FSM: IDLE, ADDR, DATA. Only one burst is outstanding at any time.
REQ-016 IDLE, with any s*_arvalid high: the winner SHALL be chosen round-robin, giving priority to the port opposite last_grant. The winner's s_arready SHALL be driven combinationally high in that same cycle. The request SHALL be latched, and the FSM SHALL go to ADDR.
REQ-017 s*_arready SHALL be 0 in every state except IDLE, and 0 for the losing port.
REQ-018 ADDR: m_arvalid SHALL be 1 and hold the latched fields stable until m_arready. m_arid SHALL be {grant, latched arid[2:0]}. On the handshake the FSM SHALL go to DATA and clear the beat counter.
REQ-019 Latency: s_arvalid and s_arready in cycle N produce m_arvalid in cycle N+1.
REQ-020 DATA: m_r* SHALL be routed combinationally to the granted port, and m_rready SHALL be s_rready[grant].
REQ-021 In DATA, the non-granted port's rvalid SHALL be 0 and its rdata/rresp/rlast SHALL be 0. Outside DATA, both ports' rvalid SHALL be 0 and m_rready SHALL be 0.
REQ-022 Each beat (m_rvalid & m_rready) SHALL increment an 8-bit beat counter.
REQ-023 On a beat with m_rlast=1: if the counter value before the increment differs from the latched arlen, o_len_err[grant] SHALL be set.
REQ-024 On a beat with m_rlast=1 the block SHALL also update last_grant, increment o_grant_cnt[grant] (wrapping 0xFFFF to 0), and return to IDLE.
REQ-025 On a beat with m_rlast=0 where the counter already equals arlen: o_len_err[grant] SHALL be set, and the beat SHALL still be forwarded.
REQ-026 Any beat with m_rresp != 2'b00 SHALL set o_rresp_err[grant].
REQ-027 If i_stat_clr coincides with a set event, the set SHALL win for that flag or counter increment. All other status bits SHALL clear.
REQ-028 If both ports request while the FSM is busy, requests SHALL wait; no request SHALL be dropped or reordered within a port.
REQ-029 A return to IDLE on RLAST SHALL allow a new grant in the very next cycle, giving zero idle cycles between bursts.

Reset
REQ-030 rst_n low SHALL asynchronously force the following: state=IDLE, last_grant=1 so port 0 wins first, m_arvalid=0, m_rready=0, all s*_arready=0, all s*_rvalid=0, all latched AR fields=0, beat counter=0, status counters and flags=0, o_busy=0.
REQ-031 rst_n asserted mid-burst SHALL abandon the burst with no completion count. After reset release, the FSM SHALL accept new requests in the first clock.

Verification
REQ-032 s0 only, arlen=3, addr=0x1000: m_araddr=0x1000, m_arid[3]=0, 4 beats reach s0, and o_grant_cnt0=1.
REQ-033 s0 and s1 request simultaneously and continuously, arlen=0: grants alternate 0,1,0,1 with back-to-back single beats, and s1_rvalid is never high during s0 data.
REQ-034 m_arready held low for 5 cycles: m_arvalid stays high with stable fields, and s1_arready stays 0 throughout.
REQ-035 arlen=7 with RLAST on beat 4: o_len_err[grant]=1 and the FSM returns to IDLE. Then i_stat_clr for 1 cycle returns o_len_err to 0.
REQ-036 RRESP=2'b10 on beat 2 of port 1: o_rresp_err=2'b10. Separately, rst_n pulsed low during DATA: all outputs read their reset values immediately.
